// File: rtl/eth_tx_arb_pkg.sv
// rtl/eth_tx_arb_pkg.sv - shared types and constants for the TX frame arbiter
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic [7:0] ABORT_DATA = 8'h00;
    localparam int         STALL_W    = 16;

endpackage

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational rotating-priority pick starting at rr_ptr
module eth_rr_pick #(
    parameter int PORTS = 4,
    parameter int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    int cand;

    // Walk from farthest to nearest so the port closest to rr_ptr wins last.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (req[cand]) begin
                found = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arb.sv
// rtl/eth_tx_frame_arb.sv - frame-granular round-robin TX arbiter; stall abort enabled by ETH_TX_ARB_TIMEOUT_EN
module eth_tx_frame_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS*8-1:0]       s_axis_tdata,
    input  logic [PORTS-1:0]         s_axis_tvalid,
    output logic [PORTS-1:0]         s_axis_tready,
    input  logic [PORTS-1:0]         s_axis_tlast,
    input  logic [PORTS-1:0]         s_axis_tuser,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [$clog2(PORTS)-1:0] grant,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_abort
);

    localparam int IDX_W = $clog2(PORTS);

    arb_state_t       state;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       lane_data [PORTS];
    logic             src_valid;
    logic             src_last;
    logic             src_user;

    eth_rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
        .req    (s_axis_tvalid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            lane_data[i] = s_axis_tdata[8*i +: 8];
        end
    end

    assign src_valid = s_axis_tvalid[grant_q];
    assign src_last  = s_axis_tlast[grant_q];
    assign src_user  = s_axis_tuser[grant_q];
    assign next_ptr  = (grant_q == IDX_W'(PORTS - 1)) ? '0 : grant_q + 1'b1;
    assign grant     = grant_q;
    assign busy      = (state != IDLE);

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (state)
            PASS: begin
                m_axis_tvalid          = src_valid;
                m_axis_tdata           = lane_data[grant_q];
                m_axis_tlast           = src_last;
                m_axis_tuser           = src_user;
                s_axis_tready[grant_q] = m_axis_tready;
            end
`ifdef ETH_TX_ARB_TIMEOUT_EN
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = ABORT_DATA;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            DRAIN: begin
                s_axis_tready[grant_q] = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign frame_done = (state == PASS) && src_valid && m_axis_tready && src_last;

`ifdef ETH_TX_ARB_TIMEOUT_EN
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_nxt;

    assign stall_nxt   = stall_cnt + 1'b1;
    assign frame_abort = (state == ABORT) && m_axis_tready;
`else
    assign frame_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state   <= PASS;
`ifdef ETH_TX_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                PASS: begin
                    if (src_valid && m_axis_tready) begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                        if (src_last) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    // Only a silent source counts; downstream backpressure never aborts.
                    else if (!src_valid) begin
                        stall_cnt <= stall_nxt;
                        if (stall_nxt == STALL_W'(TIMEOUT)) begin
                            state <= ABORT;
                        end
                    end
`endif
                end
`ifdef ETH_TX_ARB_TIMEOUT_EN
                ABORT: begin
                    if (m_axis_tready) begin
                        rr_ptr <= next_ptr;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (src_valid && src_last) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// tb/tb_eth_tx_frame_arb.sv - table and scoreboard bench for eth_tx_frame_arb
module tb_eth_tx_frame_arb;

    localparam int PORTS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [PORTS*8-1:0] s_tdata;
    logic [PORTS-1:0]  s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]        m_tdata;
    logic              m_tvalid, m_tready, m_tlast, m_tuser;
    logic [1:0]        grant;
    logic              busy, frame_done, frame_abort;

    eth_tx_frame_arb #(.PORTS(PORTS), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .grant         (grant),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         port;
        bit         first;
    } exp_t;

    typedef struct {
        bit          do_reset;
        logic [3:0]  mask;
        int          len;
        bit          user;
        bit          tog;
        logic [15:0] order;
        int          n;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];

    int  src_len[PORTS], src_pos[PORTS], stall_at[PORTS], stall_rem[PORTS];
    bit  src_act[PORTS], src_user[PORTS];
    bit  toggle, hold_low, gap_armed, seen_beat;
    int  n_checks, n_fail;
    int  done_cnt, abort_cnt, gap, cyc_in_rec, stall_seen, stall_at_abort;
    logic [PORTS-1:0] acc;

    function automatic logic [7:0] bval(int p, int i);
        return 8'(i + 37 * p + 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < PORTS; p++) begin
            logic last;
            last = (src_pos[p] == src_len[p] - 1);
            s_tvalid[p] = src_act[p] && !(src_pos[p] == stall_at[p] && stall_rem[p] > 0);
            s_tdata[p*8 +: 8] = src_act[p] ? bval(p, src_pos[p]) : 8'h00;
            s_tlast[p] = src_act[p] && last;
            s_tuser[p] = src_act[p] && last && src_user[p];
        end
        if (hold_low) m_tready = 1'b0;
        else if (toggle) m_tready = ~m_tready;
        else m_tready = 1'b1;
    endtask

    task automatic start_src(int p, int len, bit user);
        src_len[p] = len; src_pos[p] = 0; src_act[p] = 1'b1;
        src_user[p] = user; stall_at[p] = -1; stall_rem[p] = 0;
    endtask

    task automatic push_frame(int p, int npush, int len, bit user);
        for (int i = 0; i < npush; i++) begin
            sb.push_back('{bval(p, i), i == len - 1, user && (i == len - 1), p, i == 0});
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc_in_rec++;
        acc = s_tvalid & s_tready;
        if (!busy) gap++;
        if (busy && !m_tvalid) stall_seen++;
        if (frame_done) done_cnt++;
        if (frame_abort) begin
            abort_cnt++;
            stall_at_abort = stall_seen;
        end
        if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_beat: got data %0h with empty scoreboard", m_tdata);
            end else begin
                e = sb.pop_front();
                check("beat_data", m_tdata, e.data);
                check("beat_last", m_tlast, e.last);
                check("beat_user", m_tuser, e.user);
                if (e.first) begin
                    check("grant", grant, e.port);
                    if (gap_armed) check("idle_gap", gap, 1);
                end
                if (!seen_beat && !toggle) check("arb_latency", cyc_in_rec, 2);
                seen_beat = 1'b1;
            end
            if (m_tlast) begin
                gap = 0;
                gap_armed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < PORTS; p++) begin
            if (src_act[p] && !s_tvalid[p] && src_pos[p] == stall_at[p] && stall_rem[p] > 0)
                stall_rem[p]--;
            if (acc[p]) begin
                src_pos[p]++;
                if (src_pos[p] == src_len[p]) src_act[p] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic clear_rec();
        done_cnt = 0; abort_cnt = 0; gap = 0; gap_armed = 1'b0;
        cyc_in_rec = 0; seen_beat = 1'b0; stall_seen = 0; stall_at_abort = -1;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while ((src_act[0] || src_act[1] || src_act[2] || src_act[3] || busy) && n < budget) begin
            cycle();
            n++;
        end
        check("completion_in_budget", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        for (int p = 0; p < PORTS; p++) src_act[p] = 1'b0;
        sb.delete();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    task automatic run_group(logic [3:0] mask, int len, bit user, bit tog,
                             logic [15:0] order, int n);
        clear_rec();
        toggle = tog;
        for (int p = 0; p < PORTS; p++) if (mask[p]) start_src(p, len, user);
        for (int k = 0; k < n; k++) push_frame(int'(order[4*k +: 4]), len, len, user);
        drive();
        wait_done(3000);
        check("frame_done_cnt", done_cnt, n);
        check("frame_abort_cnt", abort_cnt, 0);
        check("scoreboard_empty", sb.size(), 0);
        toggle = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'b0100, 64, 1'b0, 1'b0, 16'h0002, 1};
        tbl[1] = '{1'b1, 4'b1011, 10, 1'b0, 1'b0, 16'h0310, 3};
        tbl[2] = '{1'b0, 4'b1111,  3, 1'b0, 1'b0, 16'h3210, 4};
        tbl[3] = '{1'b0, 4'b0010,  1, 1'b0, 1'b0, 16'h0001, 1};
        tbl[4] = '{1'b0, 4'b1001,  5, 1'b0, 1'b0, 16'h0003, 2};
        tbl[5] = '{1'b0, 4'b0001,  2, 1'b1, 1'b0, 16'h0000, 1};
        tbl[6] = '{1'b0, 4'b1000, 20, 1'b0, 1'b1, 16'h0003, 1};

        n_checks = 0; n_fail = 0;
        toggle = 1'b0; hold_low = 1'b0; m_tready = 1'b1;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
        for (int p = 0; p < PORTS; p++) begin
            src_act[p] = 1'b0; src_len[p] = 0; src_pos[p] = 0;
            stall_at[p] = -1; stall_rem[p] = 0; src_user[p] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_tvalid", m_tvalid, 0);
        check("reset_tdata", m_tdata, 0);
        check("reset_tlast", m_tlast, 0);
        check("reset_tuser", m_tuser, 0);
        check("reset_tready", s_tready, 0);
        check("reset_grant", grant, 0);
        check("reset_flags", {busy, frame_done, frame_abort}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();

        for (int r = 0; r < 7; r++) begin
            if (tbl[r].do_reset) do_reset();
            run_group(tbl[r].mask, tbl[r].len, tbl[r].user, tbl[r].tog,
                      tbl[r].order, tbl[r].n);
        end

        // Reset in the middle of a 60-byte frame from port 1.
        begin
            int n = 0;
            clear_rec();
            start_src(1, 60, 1'b0);
            push_frame(1, 30, 60, 1'b0);
            drive();
            while (src_pos[1] < 30 && n < 500) begin
                cycle();
                n++;
            end
            check("midframe_reach", src_pos[1], 30);
            hold_low = 1'b1;
            rst = 1'b1;
            drive();
            @(posedge clk);
            #1;
            @(negedge clk);
            check("midrst_outputs", {m_tvalid, m_tlast, m_tuser, m_tdata}, 0);
            check("midrst_tready", s_tready, 0);
            check("midrst_grant", grant, 0);
            check("midrst_busy", busy, 0);
            check("midrst_sb", sb.size(), 0);
            @(posedge clk);
            #1;
            src_act[1] = 1'b0;
            hold_low = 1'b0;
            rst = 1'b0;
            drive();
            run_group(4'b0100, 4, 1'b0, 1'b0, 16'h0002, 1);
        end

`ifdef ETH_TX_ARB_TIMEOUT_EN
        // Port 1 stalls after byte 5 for 20 cycles; port 2 waits behind it.
        do_reset();
        clear_rec();
        start_src(1, 10, 1'b0);
        stall_at[1] = 5;
        stall_rem[1] = 20;
        start_src(2, 3, 1'b0);
        push_frame(1, 5, 10, 1'b0);
        sb.push_back('{8'h00, 1'b1, 1'b1, 1, 1'b0});
        push_frame(2, 3, 3, 1'b0);
        drive();
        wait_done(3000);
        check("abort_stall_cycles", stall_at_abort, 16);
        check("abort_pulses", abort_cnt, 1);
        check("abort_done_pulses", done_cnt, 1);
        check("abort_drained_src", src_pos[1], 10);
        check("abort_sb_empty", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_arb.md
# eth_tx_frame_arb

Frame-granular round-robin arbiter sharing the single 8-bit AXI-Stream TX port of the 1G RGMII MAC (with its TX frame FIFO) among several byte-stream requesters. It sits between the packet sources (UDP/streamer engines, control-plane sender) and the MAC `tx_axis` input. It never interleaves bytes of different frames. It optionally aborts frames whose source stalls too long, so one stuck requester cannot hold the MAC.

## Interface
- `PORTS`, default 4: number of requesters, range 2..8.
- `TIMEOUT`, default 1024: source-stall cycles before abort. Used only with `ETH_TX_ARB_TIMEOUT_EN`; range 2..65535.
- `clk` in 1: 125 MHz logic clock, same as the MAC `logic_clk`.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in PORTS*8: requester data; port i occupies bits [8i+7:8i].
- `s_axis_tvalid` in PORTS: per-port valid.
- `s_axis_tready` out PORTS: per-port ready.
- `s_axis_tlast` in PORTS: per-port end of frame.
- `s_axis_tuser` in PORTS: per-port bad-frame flag, passed through.
- `m_axis_tdata` out 8, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1, `m_axis_tuser` out 1: connect to the MAC `tx_axis_*`.
- `grant` out clog2(PORTS): index of the current or last granted port.
- `busy` out 1: high while a frame is owned (PASS/ABORT/DRAIN).
- `frame_done` out 1: one-cycle pulse when a granted frame's tlast beat is accepted downstream.
- `frame_abort` out 1: one-cycle pulse when an abort beat is accepted. Tied 0 without the macro.

## Operation
- States:
  - IDLE: no frame owned.
  - PASS: granted port drives the output.
  - ABORT: emit the terminating beat. Macro only.
  - DRAIN: discard the rest of the aborted frame. Macro only.
- IDLE: if any `s_axis_tvalid` is high, select the first valid port at or after `rr_ptr`, cyclically. Register it into `grant` and go to PASS. All `s_axis_tready` are 0 in IDLE.
- PASS: combinational pass-through of the granted port.
  - `m_axis_tvalid = s_axis_tvalid[grant]`; `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` come from the granted port.
  - `s_axis_tready[grant] = m_axis_tready`; all other ready bits are 0.
- A beat with tlast accepted in PASS:
  - pulse `frame_done`;
  - set `rr_ptr = grant+1`, wrapping to 0 after PORTS-1;
  - go to IDLE.
- Fairness: a port that has just sent a frame has the lowest priority in the next arbitration.
- `tuser` is forwarded unmodified. The MAC FIFO drops frames flagged by tuser.
- Frame length is not checked. Padding and FCS are the MAC's job.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant` 0;
  - `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tuser` 0, `m_axis_tdata` 0;
  - `s_axis_tready` all 0;
  - `busy`, `frame_done` and `frame_abort` all 0;
  - stall counter 0.
- Arbitration latency: tvalid seen in IDLE at cycle N gives grant at N+1. The first beat can transfer in cycle N+1.
- Frame-to-frame gap: exactly one IDLE cycle after each tlast. This is hidden by the MAC IFG.
- Same-cycle events:
  - Requests arriving while busy wait; they are never lost because AXIS valid must hold.
  - Several ports requesting in IDLE: the round-robin order decides.
  - A port raising tvalid in the same cycle as tlast of the current frame is considered in the following IDLE cycle.
- `m_axis_tready` low stalls the transfer but never counts toward the timeout.
- Reset mid-frame: the frame is truncated with no tlast. `rst` must be shared with the MAC `logic_rst` so its frame FIFO also discards the partial frame.
- AXIS rule: once `m_axis_tvalid` is asserted in ABORT, it and its data are held until `m_axis_tready` is high.

## Configuration
- `ETH_TX_ARB_TIMEOUT_EN` defined:
  - In PASS, a 16-bit stall counter increments every cycle with `s_axis_tvalid[grant]`=0. It clears on any accepted beat and on entry to PASS.
  - When the counter reaches TIMEOUT, go to ABORT.
- ABORT: output `m_axis_tvalid`=1, tdata 0x00, tlast 1, tuser 1; all `s_axis_tready` are 0.
- Acceptance of the ABORT beat:
  - pulse `frame_abort`;
  - set `rr_ptr = grant+1`;
  - go to DRAIN.
- DRAIN:
  - `s_axis_tready[grant]`=1 and `m_axis_tvalid`=0;
  - source beats are discarded;
  - on an accepted source tlast, go to IDLE with no `frame_done` pulse.
- Without the macro: no counter, ABORT and DRAIN do not exist, and `frame_abort` is constant 0.

## Structure
- Package `eth_tx_arb_pkg`:
  - state enum (IDLE, PASS, ABORT, DRAIN);
  - `ABORT_DATA` constant 8'h00;
  - stall-counter width constant (16).
- Sub-module `eth_rr_pick`:
  - purely combinational rotating-priority encoder;
  - inputs: request vector and `rr_ptr`;
  - outputs: `found` and `index`.
- FSM, grant register, mux and counter live in the top module.

## Test plan
- Port 2 sends a 64-byte frame while other ports are idle:
  - grant=2 one cycle after tvalid;
  - 64 bytes out in order with tlast on byte 64;
  - one `frame_done` pulse.
- Ports 0, 1 and 3 valid simultaneously from reset, 10-byte frames each:
  - output order 0, 1, 3, then 0 again if re-requested;
  - exactly one IDLE cycle between frames.
- `m_axis_tready` toggles 1/0 every cycle during a 20-byte frame: all 20 bytes arrive intact, no duplicates or drops, and no abort.
- Macro on, TIMEOUT=16: port 1 stalls after byte 5 for 20 cycles:
  - abort beat (0x00, tlast=1, tuser=1) after exactly 16 stall cycles;
  - `frame_abort` pulse;
  - remaining source bytes are swallowed until tlast;
  - port 2 is granted next.
- `rst` asserted at byte 30 of a 60-byte frame: all outputs 0 next cycle and `grant`=0; a fresh request is granted normally.
- A frame with `s_axis_tuser`=1 on its tlast beat is forwarded with `m_axis_tuser`=1 and pulses `frame_done`, not `frame_abort`.
